// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage and its word FIFO.
package fetch_pkg;
  localparam int FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetched {pc, instr} words with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & (~full | do_pop) & ~flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
    count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr_q] <= wdata;
  assign rdata = mem[rd_ptr_q];
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch PC owner, imem req/ack sequencer and word FIFO toward decode.
// FETCH_BUF_BYPASS_EN: an ack into an empty FIFO is presented to decode the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_f,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pc_plus4_f
);
  localparam int CW = $clog2(DEPTH+1);
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d, pc_next;
  logic            ack, good, bypass, push, pop, space;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occ;
  fetch_entry_t    fifo_rdata, head;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ('{pc: fetch_pc_q, instr: imem_rdata}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  // Space looks at occupancy after this cycle's push/pop so a granted request can always land.
  always_comb begin
    ack     = imem_ack & imem_req;
    good    = ack & (state_q == REQ) & ~redirect_valid;
    bypass  = BYPASS & fifo_empty & good;
    push    = good & ~(bypass & instr_ready);
    pop     = instr_ready & ~fifo_empty & ~redirect_valid;
    occ     = {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop);
    space   = ~fifo_full & (occ < (CW+1)'(DEPTH));
    pc_next = fetch_pc_q + XLEN'(4);
  end
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      state_d    = (state_q != IDLE && !ack) ? DISCARD : IDLE;
    end else if (state_q == IDLE) begin
      state_d = space ? REQ : IDLE;
      addr_d  = fetch_pc_q;
    end else if (ack) begin
      fetch_pc_d = (state_q == REQ) ? pc_next : fetch_pc_q;
      state_d    = (state_q == REQ && space) ? REQ : IDLE;
      addr_d     = pc_next;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end
  always_comb begin
    head        = fifo_empty ? '{pc: fetch_pc_q, instr: imem_rdata} : fifo_rdata;
    instr_valid = ~fifo_empty | bypass;
    instr_f     = instr_valid ? head.instr : NOP_INSTR;
    pc_f        = instr_valid ? head.pc : '0;
    pc_plus4_f  = instr_valid ? head.pc + XLEN'(4) : '0;
  end
  assign imem_req  = state_q != IDLE;
  assign imem_addr = addr_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: random and directed stimulus, queue-based reference model, decoupled monitor.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} word_t;

  logic clk = 0, rst = 0, redirect_valid = 0, imem_ack = 0, instr_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instr_f, pc_f, pc_plus4_f;

  int checks = 0, passed = 0, acc_cnt = 0;
  int n, a0, vc, qs;
  word_t exp_q[$];
  word_t w;
  logic [31:0] exp_pc = 0;
  bit stale = 0, prev_redir = 0, acc;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_f(instr_f),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory answers only while a request is up; acks with no request are never sent here.
  task automatic step(input bit a, input bit r, input bit rv, input logic [31:0] rp, input logic [31:0] rd);
    @(posedge clk); #1;
    imem_ack = a & imem_req;
    instr_ready = r;
    redirect_valid = rv;
    redirect_pc = rp;
    imem_rdata = rd;
  endtask

  task automatic step_rand(input int rdy_pct);
    @(posedge clk); #1;
    imem_ack = imem_req ? ($urandom_range(99) < 60) : ($urandom_range(9) == 0);
    instr_ready = $urandom_range(99) < rdy_pct;
    redirect_valid = $urandom_range(99) < 5;
    redirect_pc = $urandom;
    imem_rdata = $urandom;
  endtask

  task automatic wait_req(input bit r);
    int k = 0;
    while (!imem_req && k < 20) begin step(0, r, 0, 0, 0); k++; end
    if (!imem_req) chk("req_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 0; imem_ack = 0; instr_ready = 0; redirect_valid = 0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_f, NOP);
    chk("rst_pc", pc_f, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  // Reference model: an accepted word is {expected pc, data}; a redirect empties the
  // queue and makes any still-open request stale so its ack is thrown away.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete(); exp_pc = 0; stale = 0; prev_redir = 0;
    end else begin
      qs = exp_q.size();
      acc = imem_req && imem_ack && !redirect_valid && !stale;
      if (prev_redir) chk("valid_after_redirect", instr_valid, 0);
      chk("instr_valid", instr_valid, (qs != 0) || (BYP && acc));
      if (imem_req && imem_ack) begin
        if (acc) begin
          chk("imem_addr", imem_addr, exp_pc);
          exp_q.push_back('{exp_pc, imem_rdata});
          exp_pc += 4;
          acc_cnt++;
        end
        stale = 0;
      end else if (imem_req && redirect_valid) stale = 1;
      if (redirect_valid) begin
        exp_q.delete();
        exp_pc = redirect_pc & ~32'h3;
      end else if (instr_valid && instr_ready && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("pc_f", pc_f, w.pc);
        chk("instr_f", instr_f, w.instr);
        chk("pc_plus4_f", pc_plus4_f, w.pc + 4);
      end
      if (!instr_valid) begin
        chk("idle_instr", instr_f, NOP);
        chk("idle_pc", pc_f, 0);
        chk("idle_pc4", pc_plus4_f, 0);
      end
      chk("model_depth_ok", exp_q.size() <= DEPTH, 1);
      prev_redir = redirect_valid;
    end
  end

  initial begin
    #3;
    chk("por_req", imem_req, 0);
    chk("por_addr", imem_addr, 0);
    chk("por_valid", instr_valid, 0);
    chk("por_instr", instr_f, NOP);
    @(posedge clk); #1 rst = 1;
    // streaming: one word per cycle once warmed up
    vc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 0, $urandom); #2;
      if (i >= 10 && instr_valid) vc++;
    end
    chk("throughput", vc, 30);
    chk("req_before_reset", imem_req, 1);
    do_reset();
    // fill with decode stalled
    a0 = acc_cnt;
    repeat (10) step(1, 0, 0, 0, $urandom);
    #2;
    chk("full_req_low", imem_req, 0);
    chk("full_pushes", acc_cnt - a0, 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0); #2;
      chk("drain_pc", pc_f, 4 * i);
    end
    // redirect with request open, stale ack afterwards
    do_reset();
    wait_req(0);
    chk("t4_addr0", imem_addr, 0);
    step(0, 0, 1, 32'h107, 0);
    step(1, 0, 0, 0, 32'hDEAD_BEEF); #2;
    chk("t4_stale_req", imem_req, 1);
    chk("t4_stale_addr", imem_addr, 0);
    step(0, 0, 0, 0, 0);
    wait_req(0);
    chk("t4_new_addr", imem_addr, 32'h104);
    step(1, 1, 0, 0, 32'h1234_5678); #2;
    n = 0;
    while (!instr_valid && n < 5) begin step(0, 1, 0, 0, 0); #2; n++; end
    chk("t4_first_pc", pc_f, 32'h104);
    chk("t4_first_instr", instr_f, 32'h1234_5678);
    // redirect + ack + pop together with two words buffered
    do_reset();
    a0 = acc_cnt; n = 0;
    while (acc_cnt - a0 < 2 && n < 20) begin step(1, 0, 0, 0, $urandom); #5; n++; end
    chk("t5_two_buffered", acc_cnt - a0, 2);
    step(1, 1, 1, 32'h200, 32'h0000_0BAD); #2;
    chk("t5_req_at_redirect", imem_req, 1);
    step(0, 0, 0, 0, 0); #2;
    chk("t5_empty1", instr_valid, 0);
    step(0, 0, 0, 0, 0); #2;
    chk("t5_empty2", instr_valid, 0);
    // ack into an empty FIFO: latency depends on the bypass build
    do_reset();
    wait_req(1);
    step(1, 1, 0, 0, 32'h0000_ABCD); #2;
    chk("t6_same_cycle_valid", instr_valid, BYP);
    step(0, 1, 0, 0, 0); #2;
    chk("t6_next_cycle_valid", instr_valid, !BYP);
    // random traffic
    do_reset();
    repeat (1500) step_rand(70);
    repeat (1500) step_rand(20);
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
